// File: rtl/glb_stream_pkg.sv
// rtl/glb_stream_pkg.sv - shared types, constants and LFSR helpers for glb_stream_source
//
// Contents:
//   state_t       per-channel FSM state (IDLE, WAIT, STREAM, DONE)
//   WAIT_CYCLES   edges spent in WAIT after a flush falling edge
//   LFSR_W        bubble LFSR width
//   LFSR_TAPS     Galois tap mask for taps 16,14,13,11
//   lfsr_next     one-step LFSR advance
//   channel_seed  per-channel seed derivation (never zero)
package glb_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int WAIT_CYCLES = 3;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Right-shifting Galois form: the bit shifted out folds back through the tap mask.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

  // An all-zero state would lock the LFSR, so it is replaced by 1.
  function automatic logic [LFSR_W-1:0] channel_seed(input logic [LFSR_W-1:0] base,
                                                     input int ch);
    logic [LFSR_W-1:0] s;
    s = base ^ LFSR_W'(ch);
    return (s == '0) ? 16'h0001 : s;
  endfunction

endpackage

// File: rtl/glb_stream_channel.sv
// rtl/glb_stream_channel.sv - one stream channel: memory, FSM, bubble LFSR and counters
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush_fall          arm pulse: restart into WAIT with a fresh size sample
//   flush_rise          abort pulse: back to IDLE unless already there
//   stall_en            enables LFSR bubble injection
//   wr_en/wr_addr/wr_data  memory write (dropped unless IDLE or DONE)
//   tx_size             requested transfer count, sampled on flush_fall
//   ready/valid/data    downstream handshake
//   done                high from completion of the last word until the next flush edge
//   tx_count            handshakes completed since the last flush_fall
module glb_stream_channel
  import glb_stream_pkg::*;
#(
  parameter int DATA_W = 17,
  parameter int DEPTH = 2048,
  parameter int STALL_THRESH = 4,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_fall,
  input  logic              flush_rise,
  input  logic              stall_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [CNT_W-1:0]  tx_size,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              done,
  output logic [CNT_W-1:0]  tx_count
);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [1:0]        wait_cnt;
  logic [CNT_W-1:0]  size;
  logic [CNT_W-1:0]  ptr;
  logic [LFSR_W-1:0] lfsr;

  logic              wr_ok;
  logic              handshake;
  logic              load_opp;
  logic              bubble;
  logic [CNT_W-1:0]  size_clamped;

  assign wr_ok        = wr_en && (state == IDLE || state == DONE);
  assign handshake    = valid && ready;
  assign load_opp     = !valid || ready;
  // Compared in 5 bits so a threshold of 16 (always stall) is representable.
  assign bubble       = stall_en && ({1'b0, lfsr[3:0]} < 5'(STALL_THRESH));
  assign size_clamped = (tx_size > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : tx_size;

  // Memory is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      valid    <= 1'b0;
      data     <= '0;
      done     <= 1'b0;
      tx_count <= '0;
      ptr      <= '0;
      size     <= '0;
      wait_cnt <= '0;
      lfsr     <= SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
      if (flush_fall) begin
        state    <= WAIT;
        wait_cnt <= 2'(WAIT_CYCLES - 1);
        size     <= size_clamped;
        ptr      <= '0;
        tx_count <= '0;
        valid    <= 1'b0;
        done     <= 1'b0;
      end else if (flush_rise && state != IDLE) begin
        state <= IDLE;
        valid <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          WAIT: begin
            if (wait_cnt == '0) begin
              if (size == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= STREAM;
              end
            end else begin
              wait_cnt <= wait_cnt - 2'd1;
            end
          end
          STREAM: begin
            if (handshake) tx_count <= tx_count + 1'b1;
            // ptr == size here, so no further load is attempted for the final word.
            if (handshake && (tx_count + 1'b1) == size) begin
              state <= DONE;
              valid <= 1'b0;
              done  <= 1'b1;
            end else if (load_opp) begin
              if (ptr < size && !bubble) begin
                valid <= 1'b1;
                data  <= mem[ptr[ADDR_W-1:0]];
                ptr   <= ptr + 1'b1;
              end else begin
                valid <= 1'b0;
              end
            end
          end
          DONE:    done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/glb_stream_source.sv
// rtl/glb_stream_source.sv - multi-channel preloadable valid/ready stream source
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush           shared arm (falling edge) / abort (rising edge) control
//   stall_en        enables per-channel LFSR bubble injection
//   cfg_wr_en       memory write strobe
//   cfg_ch          target channel; values >= NUM_CH match no channel
//   cfg_addr        write address
//   cfg_wr_data     write data
//   tx_size         per-channel transfer count, packed CNT_W per channel
//   ready           downstream ready per channel
//   valid           data valid per channel
//   data            payload, packed DATA_W per channel
//   done            channel finished
//   tx_count        completed handshakes, packed CNT_W per channel
module glb_stream_source
  import glb_stream_pkg::*;
#(
  parameter int DATA_W = 17,
  parameter int DEPTH = 2048,
  parameter int NUM_CH = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int STALL_THRESH = 4,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     stall_en,
  input  logic                     cfg_wr_en,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [DATA_W-1:0]        cfg_wr_data,
  input  logic [NUM_CH*CNT_W-1:0]  tx_size,
  input  logic [NUM_CH-1:0]        ready,
  output logic [NUM_CH-1:0]        valid,
  output logic [NUM_CH*DATA_W-1:0] data,
  output logic [NUM_CH-1:0]        done,
  output logic [NUM_CH*CNT_W-1:0]  tx_count
);

  logic flush_q;
  logic flush_fall;
  logic flush_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flush_q <= 1'b0;
    else     flush_q <= flush;
  end

  assign flush_fall = flush_q && !flush;
  assign flush_rise = flush && !flush_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    glb_stream_channel #(
      .DATA_W       (DATA_W),
      .DEPTH        (DEPTH),
      .STALL_THRESH (STALL_THRESH),
      .SEED         (channel_seed(LFSR_SEED, c))
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .flush_fall (flush_fall),
      .flush_rise (flush_rise),
      .stall_en   (stall_en),
      .wr_en      (cfg_wr_en && (cfg_ch == CH_W'(c))),
      .wr_addr    (cfg_addr),
      .wr_data    (cfg_wr_data),
      .tx_size    (tx_size[c*CNT_W +: CNT_W]),
      .ready      (ready[c]),
      .valid      (valid[c]),
      .data       (data[c*DATA_W +: DATA_W]),
      .done       (done[c]),
      .tx_count   (tx_count[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_glb_stream_source.sv
// tb/tb_glb_stream_source.sv - scoreboard bench for glb_stream_source
module tb_glb_stream_source;

  localparam int DATA_W = 17;
  localparam int DEPTH = 64;
  localparam int NUM_CH = 2;
  localparam int STALL_THRESH = 4;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CH_W = 1;
  localparam int LREF = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic stall_en = 1'b0;
  logic cfg_wr_en = 1'b0;
  logic [CH_W-1:0] cfg_ch = '0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [DATA_W-1:0] cfg_wr_data = '0;
  logic [NUM_CH*CNT_W-1:0] tx_size = '0;
  logic [NUM_CH-1:0] ready = '0;
  logic [NUM_CH-1:0] valid;
  logic [NUM_CH*DATA_W-1:0] data;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH*CNT_W-1:0] tx_count;

  glb_stream_source #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH),
    .LFSR_SEED(16'hACE1), .STALL_THRESH(STALL_THRESH)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_en(stall_en),
    .cfg_wr_en(cfg_wr_en), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
    .cfg_wr_data(cfg_wr_data), .tx_size(tx_size), .ready(ready),
    .valid(valid), .data(data), .done(done), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc;

  logic [DATA_W-1:0] mem_m [NUM_CH][DEPTH];
  logic [15:0] lfsr_ref [NUM_CH][LREF];
  logic [DATA_W-1:0] exp_q [NUM_CH][$];
  logic [1:0] tq [NUM_CH][$];
  int exp_sz [NUM_CH];

  logic [NUM_CH-1:0] pv = '0;
  logic [NUM_CH-1:0] pr = '0;
  logic pf = 1'b0;
  logic [DATA_W-1:0] pd [NUM_CH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  // Edge counter since reset release: edge k makes its bubble decision on lfsr_ref[k-1].
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      pv <= '0;
      pr <= '0;
      pf <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        logic [DATA_W-1:0] md;
        logic [DATA_W-1:0] ew;
        logic [1:0] te;
        md = data[c*DATA_W +: DATA_W];
        if (pv[c] && !pr[c] && !pf) begin
          chk($sformatf("hold_valid_ch%0d", c), 32'(valid[c]), 32'd1);
          chk($sformatf("hold_data_ch%0d", c), 32'(md), 32'(pd[c]));
        end
        if (tq[c].size() > 0) begin
          te = tq[c].pop_front();
          chk($sformatf("timing_valid_done_ch%0d_cyc%0d", c, cyc), 32'({valid[c], done[c]}), 32'(te));
        end
        if (valid[c] && ready[c]) begin
          if (exp_q[c].size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_word_ch%0d: got data %0h, want no word", c, md);
          end else begin
            ew = exp_q[c].pop_front();
            chk($sformatf("word_ch%0d", c), 32'(md), 32'(ew));
          end
        end
        pd[c] <= md;
      end
      pv <= valid;
      pr <= ready;
      pf <= flush;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int c, input int a, input logic [DATA_W-1:0] v, input logic accept);
    cfg_wr_en = 1'b1;
    cfg_ch = CH_W'(c);
    cfg_addr = ADDR_W'(a);
    cfg_wr_data = v;
    step(1);
    cfg_wr_en = 1'b0;
    if (accept) mem_m[c][a] = v;
  endtask

  task automatic set_size(input int c, input int v);
    tx_size[c*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic clear_sb();
    for (int c = 0; c < NUM_CH; c++) begin
      exp_q[c].delete();
      tq[c].delete();
    end
  endtask

  // Pulse flush; push expected words, and when timed (ready held all-ones) the
  // expected {valid,done} per cycle derived from the bubble rules.
  task automatic start(input logic timed);
    int k0;
    flush = 1'b1;
    step(1);
    clear_sb();
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("rise_valid_ch%0d", c), 32'(valid[c]), 32'd0);
      chk($sformatf("rise_done_ch%0d", c), 32'(done[c]), 32'd0);
    end
    flush = 1'b0;
    step(1);
    k0 = cyc;
    for (int c = 0; c < NUM_CH; c++) begin
      int sz;
      sz = int'(tx_size[c*CNT_W +: CNT_W]);
      if (sz > DEPTH) sz = DEPTH;
      exp_sz[c] = sz;
      for (int i = 0; i < sz; i++) exp_q[c].push_back(mem_m[c][i]);
      if (timed) begin
        int e;
        int loaded;
        repeat (3) tq[c].push_back(2'b00);
        if (sz == 0) begin
          tq[c].push_back(2'b01);
        end else begin
          tq[c].push_back(2'b00);
          e = k0 + 4;
          loaded = 0;
          while (e < LREF) begin
            if (loaded < sz) begin
              if (stall_en && int'(lfsr_ref[c][e-1][3:0]) < STALL_THRESH) tq[c].push_back(2'b00);
              else begin
                tq[c].push_back(2'b10);
                loaded++;
              end
            end else begin
              tq[c].push_back(2'b01);
              break;
            end
            e++;
          end
        end
      end
    end
  endtask

  task automatic wait_done(input logic [NUM_CH-1:0] m, input int budget);
    int n;
    n = 0;
    while ((done & m) != m && n < budget) begin
      step(1);
      n++;
    end
    chk("done_within_budget", 32'((done & m) == m), 32'd1);
    step(2);
  endtask

  task automatic end_check(input string tag);
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("%s_tx_count_ch%0d", tag, c), 32'(tx_count[c*CNT_W +: CNT_W]), 32'(exp_sz[c]));
      chk($sformatf("%s_done_ch%0d", tag, c), 32'(done[c]), 32'd1);
      chk($sformatf("%s_words_left_ch%0d", tag, c), 32'(exp_q[c].size()), 32'd0);
    end
  endtask

  task automatic reset_values(input string tag);
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("%s_valid_ch%0d", tag, c), 32'(valid[c]), 32'd0);
      chk($sformatf("%s_done_ch%0d", tag, c), 32'(done[c]), 32'd0);
      chk($sformatf("%s_tx_count_ch%0d", tag, c), 32'(tx_count[c*CNT_W +: CNT_W]), 32'd0);
      chk($sformatf("%s_data_ch%0d", tag, c), 32'(data[c*DATA_W +: DATA_W]), 32'd0);
    end
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      logic [15:0] s;
      s = 16'hACE1 ^ 16'(c);
      if (s == 16'h0000) s = 16'h0001;
      lfsr_ref[c][0] = s;
      for (int i = 1; i < LREF; i++) lfsr_ref[c][i] = ref_step(lfsr_ref[c][i-1]);
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    reset_values("reset");

    for (int c = 0; c < NUM_CH; c++)
      for (int a = 0; a < DEPTH; a++)
        wr(c, a, (c == 0 && a < 8) ? DATA_W'(32'h10 + a) : DATA_W'($urandom), 1'b1);

    // Basic stream, ch1 empty transfer alongside.
    stall_en = 1'b0;
    ready = '1;
    set_size(0, 8);
    set_size(1, 0);
    start(1'b1);
    wait_done(2'b11, 200);
    end_check("basic");

    // Backpressure: ch0 ready low for 5 cycles mid-stream.
    set_size(0, 12);
    set_size(1, 5);
    start(1'b0);
    step(6);
    ready[0] = 1'b0;
    step(5);
    ready[0] = 1'b1;
    wait_done(2'b11, 200);
    end_check("backpressure");

    // Bubble injection against the reference LFSR timeline.
    stall_en = 1'b1;
    set_size(0, 64);
    set_size(1, 20);
    start(1'b1);
    wait_done(2'b11, 600);
    end_check("bubbles");

    // Zero size and clamp to DEPTH.
    stall_en = 1'b0;
    set_size(0, 0);
    set_size(1, DEPTH + 5);
    start(1'b1);
    wait_done(2'b11, 300);
    end_check("zero_clamp");

    // Restart during word 3 of 10; a config write during STREAM must be dropped.
    set_size(0, 10);
    set_size(1, 3);
    start(1'b1);
    step(5);
    wr(0, 0, 17'h1ABCD, 1'b0);
    step(1);
    start(1'b1);
    wait_done(2'b11, 200);
    end_check("restart");

    // Write accepted in DONE, then a mid-stream asynchronous reset.
    wr(0, 0, DATA_W'($urandom), 1'b1);
    set_size(0, 20);
    set_size(1, 20);
    start(1'b0);
    step(8);
    #2;
    rst = 1'b1;
    #1;
    reset_values("async_rst");
    clear_sb();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Multi-channel with independent random ready; memory must have survived reset.
    stall_en = 1'b1;
    set_size(0, 4);
    set_size(1, 9);
    start(1'b0);
    for (int n = 0; n < 400 && done != 2'b11; n++) begin
      ready = NUM_CH'($urandom);
      step(1);
    end
    ready = '1;
    wait_done(2'b11, 50);
    end_check("multi");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
